// File: rtl/dma_param_fifo.sv
// dma_param_fifo: parametrised FWFT FIFO for the LCD DMA path with watermarks and sticky error flags.
// Define DMA_FIFO_FLUSH_EN to make fp_pulse synchronously flush the FIFO.
module dma_param_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH = 32,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pull,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       depth_left,
    output logic [AW:0]       level,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err,
    input  logic              fp_pulse
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wp, r_rp;
    logic [AW:0]       r_cnt;
    logic              r_ovf, r_udf;
    logic              w_flush, w_push_ok, w_pull_ok;

`ifdef DMA_FIFO_FLUSH_EN
    assign w_flush = fp_pulse;
`else
    logic w_unused_fp;
    assign w_unused_fp = fp_pulse;
    assign w_flush = 1'b0;
`endif

    assign full         = r_cnt == (AW+1)'(DEPTH);
    assign empty        = r_cnt == '0;
    assign almost_full  = r_cnt >= (AW+1)'(AF_LEVEL);
    assign almost_empty = r_cnt <= (AW+1)'(AE_LEVEL);
    assign level        = r_cnt;
    assign depth_left   = (AW+1)'(DEPTH) - r_cnt;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;
    assign data_out     = empty ? '0 : r_mem[r_rp];

    // Pull frees a slot in the same edge, so a full FIFO still accepts a push alongside it
    assign w_push_ok = push && (!full || pull) && !w_flush;
    assign w_pull_ok = pull && !empty && !w_flush;

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wp] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= (push && full && !pull && !w_flush) || (r_ovf && !clr_err);
            r_udf <= (pull && empty && !w_flush) || (r_udf && !clr_err);
            if (w_flush) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push_ok) r_wp <= r_wp + AW'(1);
                if (w_pull_ok) r_rp <= r_rp + AW'(1);
                if (w_push_ok != w_pull_ok) r_cnt <= w_push_ok ? r_cnt + (AW+1)'(1) : r_cnt - (AW+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_dma_param_fifo.sv
// tb_dma_param_fifo: directed bench for dma_param_fifo, default 32x32 instance plus an 8x16 wrap instance.
module tb_dma_param_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push = 1'b0, pull = 1'b0, clr_err = 1'b0, fp_pulse = 1'b0;
    logic [31:0] data_in = '0, data_out;
    logic        full, empty, almost_full, almost_empty, overflow, underflow;
    logic [5:0]  depth_left, level;

    logic        s_push = 1'b0, s_pull = 1'b0;
    logic [15:0] s_din = '0, s_dout;
    logic        s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic [3:0]  s_left, s_level;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] q[$];

    always #5 clk = ~clk;

    dma_param_fifo u_dut (
        .clk(clk), .rst_n(rst_n), .push(push), .data_in(data_in), .pull(pull),
        .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .depth_left(depth_left), .level(level),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err), .fp_pulse(fp_pulse)
    );

    dma_param_fifo #(.DATA_W(16), .DEPTH(8)) u_small (
        .clk(clk), .rst_n(rst_n), .push(s_push), .data_in(s_din), .pull(s_pull),
        .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .depth_left(s_left), .level(s_level),
        .overflow(s_ovf), .underflow(s_udf), .clr_err(1'b0), .fp_pulse(1'b0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ae", 32'(almost_empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_left", 32'(depth_left), 32);
        chk("rst_dout", data_out, 0);
        chk("rst_flags", {30'd0, overflow, underflow}, 0);
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            push = 1'b1;
            data_in = 32'h1000 + 32'(i);
            step();
            chk("fill_level", 32'(level), 32'(i + 1));
            chk("fill_af", 32'(almost_full), 32'((i + 1) >= 28));
            chk("fill_ae", 32'(almost_empty), 32'((i + 1) <= 4));
            chk("fill_dout", data_out, 32'h1000);
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_left", 32'(depth_left), 0);

        data_in = 32'hDEAD;
        step();
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_level", 32'(level), 32);
        chk("ovf_dout", data_out, 32'h1000);
        push = 1'b0;
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);

        push = 1'b1;
        pull = 1'b1;
        data_in = 32'hBEEF;
        chk("pp_head", data_out, 32'h1000);
        step();
        chk("pp_dout", data_out, 32'h1001);
        chk("pp_level", 32'(level), 32);
        chk("pp_ovf", 32'(overflow), 0);
        push = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("drain_dout", data_out, i < 31 ? 32'h1001 + 32'(i) : 32'hBEEF);
            step();
        end
        pull = 1'b0;
        chk("drain_empty", 32'(empty), 1);
        chk("drain_dout0", data_out, 0);
        chk("drain_udf", 32'(underflow), 0);

        push = 1'b1;
        pull = 1'b1;
        data_in = 32'h55;
        step();
        push = 1'b0;
        pull = 1'b0;
        chk("udf_set", 32'(underflow), 1);
        chk("udf_level", 32'(level), 1);
        chk("udf_dout", data_out, 32'h55);
        pull = 1'b1;
        clr_err = 1'b1;
        step();
        pull = 1'b0;
        clr_err = 1'b0;
        chk("udf_clr", 32'(underflow), 0);
        chk("udf_empty", 32'(empty), 1);

        for (int i = 0; i < 10; i++) begin
            push = 1'b1;
            data_in = 32'h200 + 32'(i);
            step();
        end
        fp_pulse = 1'b1;
        data_in = 32'h20A;
        step();
        fp_pulse = 1'b0;
        push = 1'b0;
`ifdef DMA_FIFO_FLUSH_EN
        chk("flush_level", 32'(level), 0);
        chk("flush_empty", 32'(empty), 1);
        chk("flush_dout", data_out, 0);
`else
        chk("flush_level", 32'(level), 11);
        chk("flush_dout", data_out, 32'h200);
`endif
        chk("flush_flags", {30'd0, overflow, underflow}, 0);

        for (int i = 0; i < 5; i++) begin
            push = 1'b1;
            data_in = 32'h300 + 32'(i);
            step();
        end
        push = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(level), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_left", 32'(depth_left), 32);
        chk("arst_dout", data_out, 0);
        step();
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            s_push = 1'b1;
            s_din = 16'hA000 + 16'(k);
            q.push_back(s_din);
            step();
        end
        chk("sm_full", 32'(s_full), 1);
        chk("sm_level", 32'(s_level), 8);
        s_pull = 1'b1;
        for (int k = 8; k < 32; k++) begin
            s_din = 16'hA000 + 16'(k);
            chk("sm_wrap_dout", 32'(s_dout), 32'(q[0]));
            void'(q.pop_front());
            q.push_back(s_din);
            step();
            chk("sm_wrap_level", 32'(s_level), 8);
        end
        s_push = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("sm_drain_dout", 32'(s_dout), 32'(q[0]));
            void'(q.pop_front());
            step();
        end
        s_pull = 1'b0;
        chk("sm_empty", 32'(s_empty), 1);
        chk("sm_errs", {30'd0, s_ovf, s_udf}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
